// File: rtl/button_conditioner_if.sv
// rtl/button_conditioner_if.sv - raw button inputs and conditioned pulse/level outputs
interface button_conditioner_if;
  logic [4:0] btn_raw;
  logic [4:0] btn_pulse;
  logic [4:0] btn_level;
  logic       any_pulse;
  logic       collision;

  modport master (
    output btn_raw,
    input  btn_pulse, btn_level, any_pulse, collision
  );

  modport slave (
    input  btn_raw,
    output btn_pulse, btn_level, any_pulse, collision
  );
endinterface

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - sync, debounce, press/auto-repeat and one-hot arbitration for five buttons
module button_conditioner #(
  parameter int         DEBOUNCE_TICKS = 4,
  parameter logic [4:0] REPEAT_MASK    = 5'b00011,
  parameter int         REPEAT_DELAY   = 100,
  parameter int         REPEAT_PERIOD  = 20
) (
  input  logic                   clk_200,
  input  logic                   rst,
  button_conditioner_if.slave    bus
);

  localparam int DB_W     = $clog2(DEBOUNCE_TICKS) + 1;
  localparam int HOLD_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int HOLD_W   = $clog2(HOLD_MAX) + 1;

  localparam logic [DB_W-1:0]   DB_LAST     = DB_W'(DEBOUNCE_TICKS - 1);
  localparam logic [HOLD_W-1:0] DELAY_LAST  = HOLD_W'(REPEAT_DELAY - 1);
  localparam logic [HOLD_W-1:0] PERIOD_LAST = HOLD_W'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_HELD   = 2'd1,
    S_REPEAT = 2'd2
  } state_t;

  logic [4:0]        r_sync1;
  logic [4:0]        r_sync2;
  logic [4:0]        r_lvl;
  logic [DB_W-1:0]   r_db_cnt   [5];
  state_t            r_state    [5];
  state_t            w_state_nxt[5];
  logic [HOLD_W-1:0] r_hold_cnt [5];
  logic [HOLD_W-1:0] w_hold_nxt [5];
  logic [4:0]        w_cand;
  logic [4:0]        w_sel;
  logic              w_multi;
  logic [4:0]        r_pulse;
  logic              r_any;
  logic              r_collision;

  // Any cycle where the synchronized input agrees with the level restarts the count.
  always_ff @(posedge clk_200 or posedge rst) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_lvl   <= '0;
      for (int i = 0; i < 5; i++) r_db_cnt[i] <= '0;
    end else begin
      r_sync1 <= bus.btn_raw;
      r_sync2 <= r_sync1;
      for (int i = 0; i < 5; i++) begin
        if (r_sync2[i] == r_lvl[i]) begin
          r_db_cnt[i] <= '0;
        end else if (r_db_cnt[i] == DB_LAST) begin
          r_lvl[i]    <= r_sync2[i];
          r_db_cnt[i] <= '0;
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_200 or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 5; i++) begin
        r_state[i]    <= S_IDLE;
        r_hold_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 5; i++) begin
        r_state[i]    <= w_state_nxt[i];
        r_hold_cnt[i] <= w_hold_nxt[i];
      end
    end
  end

  // Non-repeating buttons park in HELD with the counter saturated at the delay limit.
  always_comb begin
    for (int i = 0; i < 5; i++) begin
      w_state_nxt[i] = r_state[i];
      w_hold_nxt[i]  = r_hold_cnt[i];
      if (!r_lvl[i]) begin
        w_state_nxt[i] = S_IDLE;
        w_hold_nxt[i]  = '0;
      end else begin
        case (r_state[i])
          S_IDLE: begin
            w_state_nxt[i] = S_HELD;
            w_hold_nxt[i]  = '0;
          end
          S_HELD: begin
            if (r_hold_cnt[i] == DELAY_LAST) begin
              if (REPEAT_MASK[i]) begin
                w_state_nxt[i] = S_REPEAT;
                w_hold_nxt[i]  = '0;
              end
            end else begin
              w_hold_nxt[i] = r_hold_cnt[i] + 1'b1;
            end
          end
          S_REPEAT: begin
            if (r_hold_cnt[i] == PERIOD_LAST) w_hold_nxt[i] = '0;
            else                              w_hold_nxt[i] = r_hold_cnt[i] + 1'b1;
          end
          default: begin
            w_state_nxt[i] = S_IDLE;
            w_hold_nxt[i]  = '0;
          end
        endcase
      end
    end
  end

  // A falling level masks every candidate, so a repeat due on the release cycle is lost.
  always_comb begin
    w_cand = '0;
    for (int i = 0; i < 5; i++) begin
      if (r_lvl[i]) begin
        case (r_state[i])
          S_IDLE:   w_cand[i] = 1'b1;
          S_HELD:   w_cand[i] = REPEAT_MASK[i] && (r_hold_cnt[i] == DELAY_LAST);
          S_REPEAT: w_cand[i] = REPEAT_MASK[i] && (r_hold_cnt[i] == PERIOD_LAST);
          default:  w_cand[i] = 1'b0;
        endcase
      end
    end
  end

  always_comb begin
    w_sel = '0;
    for (int i = 0; i < 5; i++) begin
      if (w_cand[i]) begin
        w_sel    = '0;
        w_sel[i] = 1'b1;
      end
    end
    w_multi = |(w_cand & (w_cand - 5'd1));
  end

  always_ff @(posedge clk_200 or posedge rst) begin
    if (rst) begin
      r_pulse     <= '0;
      r_any       <= 1'b0;
      r_collision <= 1'b0;
    end else begin
      r_pulse     <= w_sel;
      r_any       <= |w_cand;
      r_collision <= w_multi;
    end
  end

  assign bus.btn_pulse = r_pulse;
  assign bus.btn_level = r_lvl;
  assign bus.any_pulse = r_any;
  assign bus.collision = r_collision;

endmodule

// File: tb/tb_button_conditioner.sv
// tb/tb_button_conditioner.sv - scoreboard bench for button_conditioner
module tb_button_conditioner;

  typedef struct {
    int         cyc;
    logic [4:0] pulse;
    logic       col;
  } exp_t;

  logic clk_200 = 1'b0;
  logic rst     = 1'b1;
  int   cyc     = 0;
  int   errors  = 0;
  int   checks  = 0;
  exp_t q[$];

  button_conditioner_if bus ();

  button_conditioner dut (
    .clk_200 (clk_200),
    .rst     (rst),
    .bus     (bus)
  );

  always #5 clk_200 = ~clk_200;

  always @(posedge clk_200) cyc <= cyc + 1;

  // Every nonzero pulse/collision must match the front of the expectation queue.
  always @(negedge clk_200) begin
    exp_t e;
    while (q.size() > 0 && q[0].cyc < cyc) begin
      checks++;
      errors++;
      $display("FAIL missed_pulse: expected %b at cycle %0d, still missing at cycle %0d", q[0].pulse, q[0].cyc, cyc);
      void'(q.pop_front());
    end
    if (bus.btn_pulse !== 5'b0 || bus.collision !== 1'b0) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse: got pulse=%b collision=%b at cycle %0d, none expected", bus.btn_pulse, bus.collision, cyc);
      end else begin
        e = q.pop_front();
        if (e.cyc != cyc || e.pulse !== bus.btn_pulse || e.col !== bus.collision) begin
          errors++;
          $display("FAIL pulse_match: got pulse=%b collision=%b at cycle %0d, want pulse=%b collision=%b at cycle %0d", bus.btn_pulse, bus.collision, cyc, e.pulse, e.col, e.cyc);
        end
      end
      checks++;
      if (bus.any_pulse !== (|bus.btn_pulse)) begin
        errors++;
        $display("FAIL any_pulse: got %b want %b at cycle %0d", bus.any_pulse, |bus.btn_pulse, cyc);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk_200);
  endtask

  task automatic check_level(input string name, input int idx, input logic want);
    checks++;
    if (bus.btn_level[idx] !== want) begin
      errors++;
      $display("FAIL %s: btn_level[%0d] got %b want %b at cycle %0d", name, idx, bus.btn_level[idx], want, cyc);
    end
  endtask

  task automatic check_all_zero(input string name);
    checks++;
    if (bus.btn_pulse !== 5'b0 || bus.btn_level !== 5'b0 || bus.any_pulse !== 1'b0 || bus.collision !== 1'b0) begin
      errors++;
      $display("FAIL %s: got pulse=%b level=%b any=%b collision=%b want all 0", name, bus.btn_pulse, bus.btn_level, bus.any_pulse, bus.collision);
    end
  endtask

  task automatic test_reset();
    bus.btn_raw = 5'b0;
    rst = 1'b1;
    tick(3);
    check_all_zero("reset_state");
    rst = 1'b0;
    tick(10);
    check_all_zero("after_reset_idle");
  endtask

  task automatic test_clean_press();
    int c;
    c = cyc;
    bus.btn_raw[3] = 1'b1;
    q.push_back('{c + 7, 5'b01000, 1'b0});
    tick(5);
    check_level("clean_level_pre", 3, 1'b0);
    tick(1);
    check_level("clean_level_up", 3, 1'b1);
    tick(44);
    bus.btn_raw[3] = 1'b0;
    tick(5);
    check_level("clean_level_still", 3, 1'b1);
    tick(1);
    check_level("clean_level_down", 3, 1'b0);
    tick(20);
  endtask

  task automatic test_bounce();
    bus.btn_raw[4] = 1'b1; tick(3);
    bus.btn_raw[4] = 1'b0; tick(1);
    bus.btn_raw[4] = 1'b1; tick(3);
    bus.btn_raw[4] = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick(1);
      check_level("bounce_level", 4, 1'b0);
    end
  endtask

  task automatic test_auto_repeat();
    int c;
    c = cyc;
    bus.btn_raw[1] = 1'b1;
    q.push_back('{c + 7,   5'b00010, 1'b0});
    q.push_back('{c + 107, 5'b00010, 1'b0});
    q.push_back('{c + 127, 5'b00010, 1'b0});
    q.push_back('{c + 147, 5'b00010, 1'b0});
    q.push_back('{c + 167, 5'b00010, 1'b0});
    tick(170);
    bus.btn_raw[1] = 1'b0;
    tick(5);
    check_level("repeat_level_held", 1, 1'b1);
    tick(1);
    check_level("repeat_level_released", 1, 1'b0);
    tick(30);
  endtask

  task automatic test_nonrepeat_hold();
    int c;
    c = cyc;
    bus.btn_raw[2] = 1'b1;
    q.push_back('{c + 7, 5'b00100, 1'b0});
    tick(300);
    check_level("nonrepeat_level", 2, 1'b1);
    bus.btn_raw[2] = 1'b0;
    tick(20);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL nonrepeat_queue: got %0d pending want 0", q.size());
    end
  endtask

  task automatic test_simultaneous();
    int c;
    c = cyc;
    bus.btn_raw = 5'b10001;
    q.push_back('{c + 7,   5'b10000, 1'b1});
    q.push_back('{c + 107, 5'b00001, 1'b0});
    tick(20);
    check_level("simul_level_center", 4, 1'b1);
    check_level("simul_level_down", 0, 1'b1);
    tick(92);
    bus.btn_raw = 5'b0;
    tick(30);
  endtask

  task automatic test_reset_mid_hold();
    int c;
    int r;
    c = cyc;
    bus.btn_raw[0] = 1'b1;
    q.push_back('{c + 7, 5'b00001, 1'b0});
    tick(57);
    check_level("midhold_level_pre", 0, 1'b1);
    rst = 1'b1;
    #1;
    check_all_zero("midhold_async_clear");
    tick(3);
    rst = 1'b0;
    r = cyc;
    q.push_back('{r + 7,   5'b00001, 1'b0});
    q.push_back('{r + 107, 5'b00001, 1'b0});
    tick(6);
    check_level("midhold_relevel", 0, 1'b1);
    tick(104);
    bus.btn_raw[0] = 1'b0;
    tick(30);
  endtask

  initial begin
    bus.btn_raw = 5'b0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_auto_repeat();
    test_nonrepeat_hold();
    test_simultaneous();
    test_reset_mid_hold();
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL final_queue: got %0d pending want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
